// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter sharing the single FIFO write port between NUM_REQ producers.
// Optional macro FIFO_ARB_PKT_RESERVE_EN: only grant when a full MAX_PKT_LEN packet fits.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned MAX_PKT_LEN = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [ADDR_WIDTH:0]           fifo_occupants,
  output logic                          fifo_we,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          err_overlen
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned OCC_W = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [OCC_W-1:0] FIFO_LIMIT = OCC_W'((64'd1 << ADDR_WIDTH) - 64'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(MAX_PKT_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, next_state;
  logic [PTR_W-1:0]   owner, next_owner;
  logic [PTR_W-1:0]   last_ptr, next_last_ptr;
  logic [CNT_W-1:0]   beat_cnt, next_beat_cnt;
  logic [NUM_REQ-1:0] next_grant;
  logic               next_err;
  logic               space;
  logic               admit;
  logic               pick_found;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   cand;

  assign space = (fifo_occupants < FIFO_LIMIT);

`ifdef FIFO_ARB_PKT_RESERVE_EN
  localparam int unsigned CMP_W = (OCC_W > 17) ? OCC_W : 17;
  // Headroom check; the range guard keeps the subtraction from wrapping.
  assign admit = (fifo_occupants <= FIFO_LIMIT) &&
                 ((CMP_W'(FIFO_LIMIT) - CMP_W'(fifo_occupants)) >= CMP_W'(MAX_PKT_LEN));
`else
  assign admit = 1'b1;
`endif

  // Round-robin search starting one past the previous owner.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((32'(last_ptr) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    fifo_data_in = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == PTR_W'(i)) fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state and combinational write-port outputs.
  always_comb begin
    next_state    = state;
    next_grant    = grant;
    next_owner    = owner;
    next_last_ptr = last_ptr;
    next_beat_cnt = beat_cnt;
    next_err      = 1'b0;
    req_ready     = '0;
    fifo_we       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found && admit) begin
          next_state = BURST;
          next_owner = pick;
          next_grant = NUM_REQ'(1) << pick;
        end
      end
      BURST: begin
        req_ready[owner] = space & ~rst;
        fifo_we          = req_valid[owner] & space & ~rst;
        if (fifo_we) begin
          if (req_last[owner] || (beat_cnt == LAST_BEAT)) begin
            next_state    = IDLE;
            next_grant    = '0;
            next_last_ptr = owner;
            next_beat_cnt = '0;
            next_err      = ~req_last[owner];
          end else begin
            next_beat_cnt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      last_ptr    <= PTR_W'(NUM_REQ - 1);
      beat_cnt    <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      err_overlen <= 1'b0;
    end else begin
      state       <= next_state;
      owner       <= next_owner;
      last_ptr    <= next_last_ptr;
      beat_cnt    <= next_beat_cnt;
      grant       <= next_grant;
      busy        <= (next_state == BURST);
      err_overlen <= next_err;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: queue-based requester models, write scoreboard,
// a backpressure vector table and hand sequences for overlength, stall and reset corners.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 3;
  localparam int unsigned MPL = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [AW:0]   occ;
    logic          we;
    logic [NR-1:0] rdy;
    logic [NR-1:0] gnt;
    logic          busy;
  } bp_vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic [AW:0]       fifo_occupants;
  logic              fifo_we;
  logic [DW-1:0]     fifo_data_in;
  logic [NR-1:0]     grant;
  logic              busy;
  logic              err_overlen;

  beat_t             src_q[NR][$];
  logic [DW-1:0]     exp_q[$];
  logic [NR-1:0]     exp_grant_q[$];
  logic [NR-1:0]     stall;
  logic [NR-1:0]     prev_grant;
  int                nvec, nerr, err_cnt, idle_run;
  bit                bubble_chk, had_grant;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_PKT_LEN(MPL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_occupants(fifo_occupants), .fifo_we(fifo_we),
    .fifo_data_in(fifo_data_in), .grant(grant), .busy(busy), .err_overlen(err_overlen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_pkt(input int r, input int n, input int tag);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = DW'(r * 64 + tag * 8 + k);
      b.last = (k == n - 1);
      src_q[r].push_back(b);
      exp_q.push_back(b.data);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0 && !stall[i]) begin
        req_valid[i]         = 1'b1;
        req_last[i]          = src_q[i][0].last;
        req_data[i*DW +: DW] = src_q[i][0].data;
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  function automatic bit all_empty();
    bit e = (exp_q.size() == 0);
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t = 0;
    while (!all_empty() && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!all_empty()) begin
      nvec++;
      nerr++;
      $display("FAIL %s_timeout: got %0d beats pending expected 0", name, exp_q.size());
    end
    idle(2);
    chk({name, "_grants_left"}, 32'(exp_grant_q.size()), 32'd0);
  endtask

  task automatic wait_src_size(input int r, input int sz);
    int t = 0;
    while (src_q[r].size() != sz && t < 30) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (src_q[r].size() != sz) begin
      nvec++;
      nerr++;
      $display("FAIL wait_src%0d: got %0d beats left expected %0d", r, src_q[r].size(), sz);
    end
  endtask

  // Input driver: new stimulus just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    drive();
  end

  // Monitor: scoreboard, handshakes, grant order and inter-packet bubble.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (fifo_we) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_write: got data %0h expected no write", fifo_data_in);
        end else begin
          chk("wr_data", 32'(fifo_data_in), 32'(exp_q.pop_front()));
        end
      end
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (err_overlen) err_cnt++;
      if (grant != 0 && prev_grant == 0) begin
        if (exp_grant_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_grant: got %0h expected none", grant);
        end else begin
          chk("grant_order", 32'(grant), 32'(exp_grant_q.pop_front()));
        end
        if (bubble_chk && had_grant) chk("bubble", 32'(idle_run), 32'd1);
        had_grant = 1'b1;
      end
      if (grant == 0) idle_run++;
      else idle_run = 0;
    end
    prev_grant = grant;
  end

  initial begin
    bp_vec_t bp_tab[7];
    int      e0;
    bit      found;

    // occ, we, req_ready, grant, busy per cycle from the arbitration cycle onward.
    bp_tab[0] = '{occ: 4'd3, we: 1'b0, rdy: 4'b0000, gnt: 4'b0000, busy: 1'b0};
    bp_tab[1] = '{occ: 4'd7, we: 1'b0, rdy: 4'b0000, gnt: 4'b0100, busy: 1'b1};
    bp_tab[2] = '{occ: 4'd7, we: 1'b0, rdy: 4'b0000, gnt: 4'b0100, busy: 1'b1};
    bp_tab[3] = '{occ: 4'd6, we: 1'b1, rdy: 4'b0100, gnt: 4'b0100, busy: 1'b1};
    bp_tab[4] = '{occ: 4'd7, we: 1'b0, rdy: 4'b0000, gnt: 4'b0100, busy: 1'b1};
    bp_tab[5] = '{occ: 4'd6, we: 1'b1, rdy: 4'b0100, gnt: 4'b0100, busy: 1'b1};
    bp_tab[6] = '{occ: 4'd0, we: 1'b0, rdy: 4'b0000, gnt: 4'b0000, busy: 1'b0};

    nvec = 0; nerr = 0; err_cnt = 0; idle_run = 0;
    bubble_chk = 1'b0; had_grant = 1'b0; prev_grant = '0;
    rst = 1'b1; stall = '0; fifo_occupants = '0;
    req_valid = '0; req_last = '0; req_data = '0;

    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_overlen), 32'd0);
    chk("rst_we", 32'(fifo_we), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    #1 rst = 1'b0;

    // Round-robin: all four requesters with 3-beat packets, requester 0 has a second one.
    bubble_chk = 1'b1;
    had_grant  = 1'b0;
    load_pkt(0, 3, 0); load_pkt(1, 3, 0); load_pkt(2, 3, 0); load_pkt(3, 3, 0); load_pkt(0, 3, 1);
    exp_grant_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    wait_drain("rr", 60);
    bubble_chk = 1'b0;
    chk("rr_no_overlen", 32'(err_cnt), 32'd0);

    // Backpressure from occupancy, cycle by cycle.
    load_pkt(2, 2, 1);
    exp_grant_q.push_back(4'b0100);
    for (int v = 0; v < 7; v++) begin
      @(posedge clk);
      #1 fifo_occupants = bp_tab[v].occ;
      @(negedge clk);
      chk($sformatf("bp_we[%0d]", v), 32'(fifo_we), 32'(bp_tab[v].we));
      chk($sformatf("bp_ready[%0d]", v), 32'(req_ready), 32'(bp_tab[v].rdy));
      chk($sformatf("bp_grant[%0d]", v), 32'(grant), 32'(bp_tab[v].gnt));
      chk($sformatf("bp_busy[%0d]", v), 32'(busy), 32'(bp_tab[v].busy));
    end
    #1 fifo_occupants = '0;
    wait_drain("bp", 20);

    // Overlength: 6 beats against a 4-beat limit splits into two grants.
    e0 = err_cnt;
    load_pkt(1, 6, 2);
    exp_grant_q = '{4'b0010, 4'b0010};
    wait_drain("overlen", 40);
    chk("overlen_pulses", 32'(err_cnt - e0), 32'd1);
    chk("overlen_pulse_clear", 32'(err_overlen), 32'd0);

    // Reset on beat 2 of a burst, then requester 0 must win the next arbitration.
    load_pkt(2, 4, 3);
    exp_grant_q.push_back(4'b0100);
    wait_src_size(2, 2);
    rst = 1'b1;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    exp_grant_q.delete();
    #1;
    chk("rstmid_we", 32'(fifo_we), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rstmid_grant", 32'(grant), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    load_pkt(0, 2, 4);
    load_pkt(2, 2, 4);
    exp_grant_q = '{4'b0001, 4'b0100};
    wait_drain("rstmid", 40);

    // Mid-packet stall: owner drops valid for 5 cycles after 2 beats.
    load_pkt(3, 4, 5);
    exp_grant_q.push_back(4'b1000);
    wait_src_size(3, 2);
    stall[3] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_grant", 32'(grant), 32'b1000);
      chk("stall_we", 32'(fifo_we), 32'd0);
    end
    #1 stall[3] = 1'b0;
    wait_drain("stall", 30);

`ifdef FIFO_ARB_PKT_RESERVE_EN
    // Reservation: no grant until a whole max-length packet fits, then no stall.
    fifo_occupants = 4'd5;
    load_pkt(0, 4, 6);
    exp_grant_q.push_back(4'b0001);
    repeat (3) begin
      @(negedge clk);
      chk("rsv_nogrant", 32'(grant), 32'd0);
    end
    #1 fifo_occupants = 4'd3;
    found = 1'b0;
    for (int t = 0; t < 5 && !found; t++) begin
      @(negedge clk);
      if (grant != 0) found = 1'b1;
    end
    chk("rsv_granted", 32'(found), 32'd1);
    chk("rsv_we0", 32'(fifo_we), 32'd1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rsv_we%0d", k), 32'(fifo_we), 32'd1);
    end
    #1 fifo_occupants = '0;
    wait_drain("rsv", 20);
`else
    found = 1'b0;
    chk("final_found_clear", 32'(found), 32'(exp_grant_q.size()));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin packet arbiter that shares the single write port of the on-chip `fifo` between `NUM_REQ` producers. Each producer offers packets over a valid/ready/last stream. The arbiter grants one producer for a whole packet, forwards its beats to `fifo` `we`/`data_in`, and applies backpressure from the FIFO occupancy count. It sits directly in front of the shared FIFO instance; the FIFO read side is untouched.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: beat width; matches the FIFO.
- `ADDR_WIDTH`, 24: FIFO address width. The FIFO capacity is `2**ADDR_WIDTH`; its usable limit is `2**ADDR_WIDTH - 1`.
- `MAX_PKT_LEN`, 64: maximum number of beats per packet, 1..65535.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester beat valid.
- `req_last` in `NUM_REQ`: per-requester last beat of packet.
- `req_data` in `NUM_REQ*DATA_WIDTH`: requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` out `NUM_REQ`: beat accepted when `req_valid[i] & req_ready[i]`.
- `fifo_occupants` in `ADDR_WIDTH+1`: the FIFO occupancy count.
- `fifo_we` out 1: FIFO write enable.
- `fifo_data_in` out `DATA_WIDTH`: FIFO write data.
- `grant` out `NUM_REQ`: one-hot current owner; all zero when idle.
- `busy` out 1: a packet is in progress.
- `err_overlen` out 1: one-cycle pulse when a packet is force-terminated.

## Operation
- **Space signal.** `space = (fifo_occupants < 2**ADDR_WIDTH - 1)`. Compare at `ADDR_WIDTH+1` bits so there is no truncation.
- **State machine:** IDLE and BURST.
- **IDLE**
  - `grant = 0`, `req_ready = 0`, `fifo_we = 0`.
  - If any `req_valid` bit is set and the admit condition holds (see Configuration), select the first requester with `req_valid` set.
  - The search starts at index `(last_ptr+1) mod NUM_REQ` and wraps.
  - Register that requester's one-hot in `grant` and go to BURST.
- **BURST**, owner g:
  - `req_ready[g] = space`; all other `req_ready` bits are 0.
  - `fifo_we = req_valid[g] & space`.
  - `fifo_data_in` = slice g of `req_data`, combinationally.
  - Each accepted beat increments the 16-bit `beat_cnt`.
- **Packet end**
  - The packet ends on the accepted beat with `req_last[g]=1`, or on the accepted beat where `beat_cnt == MAX_PKT_LEN-1` with `req_last[g]=0`.
  - The forced case pulses `err_overlen` on the cycle after that beat.
  - Either case: `last_ptr <= g`, `beat_cnt <= 0`, next state IDLE.
  - After a forced end, the owner's remaining beats are arbitrated as a new packet.
- **Owner behaviour.** The owner dropping `req_valid` mid-packet only stalls the burst. There is no timeout and the grant is held.
- `busy = (state == BURST)`.
- **Reset values:** state IDLE, `last_ptr = NUM_REQ-1` (so requester 0 wins first), `beat_cnt = 0`, `grant = 0`, `err_overlen = 0`.
- **Reset mid-packet:** the burst is abandoned with no flush. `fifo_we` is 0 in the reset cycle.

## Timing
- `fifo_we`, `fifo_data_in` and `req_ready` are combinational from registered state plus `req_valid`/`fifo_occupants`.
- The FIFO registers occupancy one cycle after `we`, so a full FIFO deasserts `space` from the next beat onward. The FIFO is never written beyond `2**ADDR_WIDTH - 1`.
- **Arbitration latency:** one cycle from IDLE with `req_valid` to the first possible accepted beat, which is in the BURST cycle.
- **Inter-packet bubble:** exactly one IDLE cycle between consecutive packets, including back-to-back packets from the same requester.
- **Throughput:** one beat per cycle while `req_valid[g]` and `space` both hold.
- `grant`, `busy` and `err_overlen` are registered.

## Configuration
- **Macro:** `FIFO_ARB_PKT_RESERVE_EN`.
- **Defined:**
  - IDLE admits a grant only if `(2**ADDR_WIDTH - 1) - fifo_occupants >= MAX_PKT_LEN`.
  - Once granted, an in-spec packet never stalls on `space`; `space` is still gated for safety.
  - Requesters keep their `req_valid` while waiting.
- **Undefined:** IDLE admits on any `req_valid` regardless of space; backpressure is beat-level only.

## Test plan
- **Round-robin:** all 4 requesters hold 3-beat packets from reset → grant order 0,1,2,3,0; each packet is 3 `fifo_we` pulses with the owner's data, and 1 idle cycle between packets.
- **Backpressure:** `ADDR_WIDTH=3`, hold `fifo_occupants=7` → `fifo_we=0`, `req_ready=0` during BURST; drop to 6 → exactly one beat is written.
- **Overlength:** `MAX_PKT_LEN=4`, requester 1 sends 6 beats with `req_last` on beat 6 → 4 beats written, `err_overlen` pulses once, and the remaining 2 beats are written in a later grant.
- **Mid-packet stall:** owner drops `req_valid` for 5 cycles → `grant` is unchanged, no writes occur, and the stream resumes with no beat lost or duplicated.
- **Reset mid-burst:** assert `rst` on beat 2 → next cycle `grant=0`, `busy=0`; the next arbitration grants requester 0.
- **With `FIFO_ARB_PKT_RESERVE_EN`:** `ADDR_WIDTH=6`, `MAX_PKT_LEN=16`, `fifo_occupants=50` → no grant; at 47 → grant issued and 16 beats stream without a stall.
